// File: rtl/bus_interconnect.sv
// Shared-bus interconnect: two masters, two plain slaves and one split-capable
// slave. Fixed-priority arbitration (m1 > m2), address decode on the top two
// address bits, combinational forward/return muxing, and split parking/resume.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | no owner; arbitrate split resume, then m1, then m2
// GRANTED      | one master owns the bus and talks to the decoded target
// SPLIT_RESUME | split slave returns deferred read data to the parked master
module bus_interconnect #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // master 1
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_address_out,
    input  logic              m1_address_out_valid,
    input  logic [DATA_W-1:0] m1_data_out,
    input  logic              m1_data_out_valid,
    input  logic              m1_rw,
    input  logic              m1_ready,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m1_data_in,
    output logic              m1_data_in_valid,
    output logic              m1_ack,
    output logic              m1_split_ack,
    // master 2
    input  logic              m2_req,
    input  logic [ADDR_W-1:0] m2_address_out,
    input  logic              m2_address_out_valid,
    input  logic [DATA_W-1:0] m2_data_out,
    input  logic              m2_data_out_valid,
    input  logic              m2_rw,
    input  logic              m2_ready,
    output logic              m2_grant,
    output logic [DATA_W-1:0] m2_data_in,
    output logic              m2_data_in_valid,
    output logic              m2_ack,
    output logic              m2_split_ack,
    // slave 1
    input  logic              s1_ready,
    input  logic              s1_ack,
    input  logic [DATA_W-1:0] s1_data_out,
    input  logic              s1_data_out_valid,
    output logic [ADDR_W-1:0] s1_address_in,
    output logic              s1_address_in_valid,
    output logic [DATA_W-1:0] s1_data_in,
    output logic              s1_data_in_valid,
    output logic              s1_rw,
    // slave 2
    input  logic              s2_ready,
    input  logic              s2_ack,
    input  logic [DATA_W-1:0] s2_data_out,
    input  logic              s2_data_out_valid,
    output logic [ADDR_W-1:0] s2_address_in,
    output logic              s2_address_in_valid,
    output logic [DATA_W-1:0] s2_data_in,
    output logic              s2_data_in_valid,
    output logic              s2_rw,
    // split-capable slave
    input  logic              split_s_ready,
    input  logic              split_s_ack,
    input  logic [DATA_W-1:0] split_s_data_out,
    input  logic              split_s_data_out_valid,
    input  logic              split_s_split_ack,
    input  logic              split_s_req,
    output logic [ADDR_W-1:0] split_s_address_in,
    output logic              split_s_address_in_valid,
    output logic [DATA_W-1:0] split_s_data_in,
    output logic              split_s_data_in_valid,
    output logic              split_s_rw,
    output logic              split_s_grant
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        GRANTED      = 2'd1,
        SPLIT_RESUME = 2'd2
    } state_t;

    localparam logic [1:0] T_S1   = 2'b00;
    localparam logic [1:0] T_S2   = 2'b01;
    localparam logic [1:0] T_SPL  = 2'b10;
    localparam logic [1:0] T_NONE = 2'b11;

    state_t            state, state_n;
    logic              owner, owner_n;       // 0 = m1, 1 = m2
    logic              split_pend, split_owner;
    logic              set_split, clr_split;
    logic [1:0]        tgt_q, tgt;
    logic              unm_ack_q, unm_rd_q;

    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    logic              g_aval, g_dval, g_rw, g_req;
    logic              granted, resume, sel_ready;

    logic              r_ack, r_dval, r_split;
    logic [DATA_W-1:0] r_data;
    logic              ret_owner, ret_active;
    logic              park_ready, m1_elig, m2_elig;

    assign granted       = (state == GRANTED);
    assign resume        = (state == SPLIT_RESUME);
    assign split_s_grant = resume;

    // Select the owning master's forward signals.
    always_comb begin
        g_addr = owner ? m2_address_out       : m1_address_out;
        g_aval = owner ? m2_address_out_valid : m1_address_out_valid;
        g_data = owner ? m2_data_out          : m1_data_out;
        g_dval = owner ? m2_data_out_valid    : m1_data_out_valid;
        g_rw   = owner ? m2_rw                : m1_rw;
        g_req  = owner ? m2_req               : m1_req;
    end

    // Live decode while the address is valid, latched target otherwise.
    always_comb begin
        tgt = tgt_q;
        if (granted && g_aval) tgt = g_addr[ADDR_W-1 -: 2];
    end

    // Target readiness; a busy split slave stalls new requests to it.
    always_comb begin
        sel_ready = 1'b1;
        case (tgt)
            T_S1:    sel_ready = s1_ready;
            T_S2:    sel_ready = s2_ready;
            T_SPL:   sel_ready = split_s_ready && !split_pend;
            default: sel_ready = 1'b1;
        endcase
    end

    // Forward path: only the selected target sees the owner's request.
    always_comb begin
        s1_address_in = '0; s1_address_in_valid = 1'b0; s1_data_in = '0;
        s1_data_in_valid = 1'b0; s1_rw = 1'b0;
        s2_address_in = '0; s2_address_in_valid = 1'b0; s2_data_in = '0;
        s2_data_in_valid = 1'b0; s2_rw = 1'b0;
        split_s_address_in = '0; split_s_address_in_valid = 1'b0; split_s_data_in = '0;
        split_s_data_in_valid = 1'b0; split_s_rw = 1'b0;
        if (granted) begin
            case (tgt)
                T_S1: begin
                    s1_address_in       = g_addr;
                    s1_address_in_valid = g_aval && sel_ready;
                    s1_data_in          = g_data;
                    s1_data_in_valid    = g_dval && sel_ready;
                    s1_rw               = g_rw;
                end
                T_S2: begin
                    s2_address_in       = g_addr;
                    s2_address_in_valid = g_aval && sel_ready;
                    s2_data_in          = g_data;
                    s2_data_in_valid    = g_dval && sel_ready;
                    s2_rw               = g_rw;
                end
                T_SPL: begin
                    split_s_address_in       = g_addr;
                    split_s_address_in_valid = g_aval && sel_ready;
                    split_s_data_in          = g_data;
                    split_s_data_in_valid    = g_dval && sel_ready;
                    split_s_rw               = g_rw;
                end
                default: ;
            endcase
        end
    end

    // Return path mux; unmapped addresses are answered by the bus itself.
    always_comb begin
        r_ack = 1'b0; r_data = '0; r_dval = 1'b0; r_split = 1'b0;
        if (granted) begin
            case (tgt)
                T_S1: begin
                    r_ack = s1_ack; r_data = s1_data_out; r_dval = s1_data_out_valid;
                end
                T_S2: begin
                    r_ack = s2_ack; r_data = s2_data_out; r_dval = s2_data_out_valid;
                end
                T_SPL: begin
                    r_ack   = split_s_ack;
                    r_data  = split_s_data_out;
                    r_dval  = split_s_data_out_valid;
                    r_split = split_s_split_ack && !split_pend;
                end
                default: begin
                    r_ack  = unm_ack_q;
                    r_dval = unm_ack_q && unm_rd_q;
                end
            endcase
        end else if (resume) begin
            r_ack  = split_s_ack;
            r_data = split_s_data_out;
            r_dval = split_s_data_out_valid;
        end
    end

    // Steer grant and return signals to the current owner only.
    always_comb begin
        ret_owner  = resume ? split_owner : owner;
        ret_active = granted || resume;
        m1_grant = (granted && !owner) || (resume && !split_owner);
        m2_grant = (granted &&  owner) || (resume &&  split_owner);
        m1_ack = 1'b0; m1_data_in = '0; m1_data_in_valid = 1'b0; m1_split_ack = 1'b0;
        m2_ack = 1'b0; m2_data_in = '0; m2_data_in_valid = 1'b0; m2_split_ack = 1'b0;
        if (ret_active && !ret_owner) begin
            m1_ack = r_ack; m1_data_in = r_data; m1_data_in_valid = r_dval;
            m1_split_ack = r_split;
        end
        if (ret_active && ret_owner) begin
            m2_ack = r_ack; m2_data_in = r_data; m2_data_in_valid = r_dval;
            m2_split_ack = r_split;
        end
    end

    // Next-state: split resume beats new requests; a parked master waits.
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        set_split  = 1'b0;
        clr_split  = 1'b0;
        park_ready = split_owner ? m2_ready : m1_ready;
        m1_elig    = m1_req && !(split_pend && !split_owner);
        m2_elig    = m2_req && !(split_pend &&  split_owner);
        case (state)
            IDLE: begin
                if (split_pend && split_s_req && park_ready) begin
                    state_n = SPLIT_RESUME;
                end else if (m1_elig) begin
                    state_n = GRANTED;
                    owner_n = 1'b0;
                end else if (m2_elig) begin
                    state_n = GRANTED;
                    owner_n = 1'b1;
                end
            end
            GRANTED: begin
                if (r_split) begin
                    state_n   = IDLE;
                    set_split = 1'b1;
                end else if (!g_req) begin
                    state_n = IDLE;
                end
            end
            SPLIT_RESUME: begin
                if (!split_s_req) begin
                    state_n   = IDLE;
                    clr_split = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Owner, split bookkeeping and latched target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= 1'b0;
            split_pend  <= 1'b0;
            split_owner <= 1'b0;
            tgt_q       <= T_S1;
        end else begin
            owner <= owner_n;
            if (set_split) begin
                split_pend  <= 1'b1;
                split_owner <= owner;
            end else if (clr_split) begin
                split_pend <= 1'b0;
            end
            if (granted && g_aval) tgt_q <= g_addr[ADDR_W-1 -: 2];
        end
    end

    // One-cycle bus ack (plus zero read data) for unmapped addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unm_ack_q <= 1'b0;
            unm_rd_q  <= 1'b0;
        end else begin
            unm_ack_q <= granted && g_aval && (g_addr[ADDR_W-1 -: 2] == T_NONE) && !unm_ack_q;
            if (granted && g_aval) unm_rd_q <= !g_rw;
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect with behavioural slaves and a
// queue-based scoreboard checked by a negedge monitor.
module tb_bus_interconnect;

    localparam int READ_LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m1_req, m1_address_out_valid, m1_data_out_valid, m1_rw, m1_ready;
    logic [15:0] m1_address_out;
    logic [7:0]  m1_data_out;
    logic        m2_req, m2_address_out_valid, m2_data_out_valid, m2_rw, m2_ready;
    logic [15:0] m2_address_out;
    logic [7:0]  m2_data_out;
    logic        m1_grant, m1_data_in_valid, m1_ack, m1_split_ack;
    logic [7:0]  m1_data_in;
    logic        m2_grant, m2_data_in_valid, m2_ack, m2_split_ack;
    logic [7:0]  m2_data_in;
    logic        s1_ready, s1_ack, s1_data_out_valid;
    logic [7:0]  s1_data_out;
    logic [15:0] s1_address_in;
    logic        s1_address_in_valid, s1_data_in_valid, s1_rw;
    logic [7:0]  s1_data_in;
    logic        s2_ready, s2_ack, s2_data_out_valid;
    logic [7:0]  s2_data_out;
    logic [15:0] s2_address_in;
    logic        s2_address_in_valid, s2_data_in_valid, s2_rw;
    logic [7:0]  s2_data_in;
    logic        split_s_ready, split_s_ack, split_s_data_out_valid, split_s_split_ack, split_s_req;
    logic [7:0]  split_s_data_out;
    logic [15:0] split_s_address_in;
    logic        split_s_address_in_valid, split_s_data_in_valid, split_s_rw, split_s_grant;
    logic [7:0]  split_s_data_in;

    logic [105:0] all_out;
    assign all_out = {m1_grant, m1_data_in, m1_data_in_valid, m1_ack, m1_split_ack,
                      m2_grant, m2_data_in, m2_data_in_valid, m2_ack, m2_split_ack,
                      s1_address_in, s1_address_in_valid, s1_data_in, s1_data_in_valid, s1_rw,
                      s2_address_in, s2_address_in_valid, s2_data_in, s2_data_in_valid, s2_rw,
                      split_s_address_in, split_s_address_in_valid, split_s_data_in,
                      split_s_data_in_valid, split_s_rw, split_s_grant};

    bus_interconnect #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m1_req(m1_req), .m1_address_out(m1_address_out), .m1_address_out_valid(m1_address_out_valid),
        .m1_data_out(m1_data_out), .m1_data_out_valid(m1_data_out_valid), .m1_rw(m1_rw),
        .m1_ready(m1_ready), .m1_grant(m1_grant), .m1_data_in(m1_data_in),
        .m1_data_in_valid(m1_data_in_valid), .m1_ack(m1_ack), .m1_split_ack(m1_split_ack),
        .m2_req(m2_req), .m2_address_out(m2_address_out), .m2_address_out_valid(m2_address_out_valid),
        .m2_data_out(m2_data_out), .m2_data_out_valid(m2_data_out_valid), .m2_rw(m2_rw),
        .m2_ready(m2_ready), .m2_grant(m2_grant), .m2_data_in(m2_data_in),
        .m2_data_in_valid(m2_data_in_valid), .m2_ack(m2_ack), .m2_split_ack(m2_split_ack),
        .s1_ready(s1_ready), .s1_ack(s1_ack), .s1_data_out(s1_data_out),
        .s1_data_out_valid(s1_data_out_valid), .s1_address_in(s1_address_in),
        .s1_address_in_valid(s1_address_in_valid), .s1_data_in(s1_data_in),
        .s1_data_in_valid(s1_data_in_valid), .s1_rw(s1_rw),
        .s2_ready(s2_ready), .s2_ack(s2_ack), .s2_data_out(s2_data_out),
        .s2_data_out_valid(s2_data_out_valid), .s2_address_in(s2_address_in),
        .s2_address_in_valid(s2_address_in_valid), .s2_data_in(s2_data_in),
        .s2_data_in_valid(s2_data_in_valid), .s2_rw(s2_rw),
        .split_s_ready(split_s_ready), .split_s_ack(split_s_ack), .split_s_data_out(split_s_data_out),
        .split_s_data_out_valid(split_s_data_out_valid), .split_s_split_ack(split_s_split_ack),
        .split_s_req(split_s_req), .split_s_address_in(split_s_address_in),
        .split_s_address_in_valid(split_s_address_in_valid), .split_s_data_in(split_s_data_in),
        .split_s_data_in_valid(split_s_data_in_valid), .split_s_rw(split_s_rw),
        .split_s_grant(split_s_grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gcyc[3];
    int rcyc[3];
    int relcyc[3];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];
    int m1_dv = 0, m2_dv = 0, m1_sa = 0, m2_sa = 0;
    int s1_av = 0, s1_wr = 0, s1_rd = 0, s2_wr = 0, s2_rd = 0;
    int sp_wr = 0, sp_rd = 0, sp_sa = 0, sp_dov = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain slave 1: registered ack, read data returned with the ack.
    logic [7:0] mem1 [256];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ack <= 1'b0; s1_data_out_valid <= 1'b0; s1_data_out <= 8'h00;
        end else begin
            s1_ack <= 1'b0; s1_data_out_valid <= 1'b0;
            if (s1_address_in_valid) s1_av <= s1_av + 1;
            if (s1_address_in_valid && !s1_ack) begin
                s1_ack <= 1'b1;
                if (s1_rw) begin
                    if (s1_data_in_valid) mem1[s1_address_in[7:0]] <= s1_data_in;
                    s1_wr <= s1_wr + 1;
                end else begin
                    s1_data_out <= mem1[s1_address_in[7:0]];
                    s1_data_out_valid <= 1'b1;
                    s1_rd <= s1_rd + 1;
                end
            end
        end
    end

    // Plain slave 2.
    logic [7:0] mem2 [256];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_ack <= 1'b0; s2_data_out_valid <= 1'b0; s2_data_out <= 8'h00;
        end else begin
            s2_ack <= 1'b0; s2_data_out_valid <= 1'b0;
            if (s2_address_in_valid && !s2_ack) begin
                s2_ack <= 1'b1;
                if (s2_rw) begin
                    if (s2_data_in_valid) mem2[s2_address_in[7:0]] <= s2_data_in;
                    s2_wr <= s2_wr + 1;
                end else begin
                    s2_data_out <= mem2[s2_address_in[7:0]];
                    s2_data_out_valid <= 1'b1;
                    s2_rd <= s2_rd + 1;
                end
            end
        end
    end

    // Split slave: writes ack directly, reads split and return after a latency.
    logic [7:0] memsp [256];
    logic [7:0] sp_addr;
    int sp_phase = 0;
    int sp_cnt   = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_s_ack <= 1'b0; split_s_split_ack <= 1'b0; split_s_data_out_valid <= 1'b0;
            split_s_data_out <= 8'h00; split_s_req <= 1'b0; sp_phase <= 0; sp_cnt <= 0;
            sp_addr <= 8'h00;
        end else begin
            split_s_ack <= 1'b0; split_s_split_ack <= 1'b0; split_s_data_out_valid <= 1'b0;
            case (sp_phase)
                0: if (split_s_address_in_valid && !split_s_ack && !split_s_split_ack) begin
                    if (split_s_rw) begin
                        if (split_s_data_in_valid) memsp[split_s_address_in[7:0]] <= split_s_data_in;
                        split_s_ack <= 1'b1;
                        sp_wr <= sp_wr + 1;
                    end else begin
                        split_s_split_ack <= 1'b1;
                        sp_sa <= sp_sa + 1;
                        sp_rd <= sp_rd + 1;
                        sp_addr <= split_s_address_in[7:0];
                        sp_cnt <= READ_LATENCY;
                        sp_phase <= 1;
                    end
                end
                1: if (sp_cnt <= 1) begin
                    split_s_req <= 1'b1;
                    sp_phase <= 2;
                end else begin
                    sp_cnt <= sp_cnt - 1;
                end
                2: if (split_s_grant) begin
                    split_s_data_out <= memsp[sp_addr];
                    split_s_data_out_valid <= 1'b1;
                    split_s_ack <= 1'b1;
                    sp_dov <= sp_dov + 1;
                    sp_phase <= 3;
                end
                default: begin
                    split_s_req <= 1'b0;
                    sp_phase <= 0;
                end
            endcase
        end
    end

    // Scoreboard monitor: every read-data strobe pops its master's queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m1_data_in_valid) begin
                m1_dv++;
                if (exp_q1.size() == 0) chk("m1_unexpected_data", {24'h0, m1_data_in}, 32'hFFFF_FFFF);
                else chk("m1_read_data", {24'h0, m1_data_in}, {24'h0, exp_q1.pop_front()});
            end
            if (m2_data_in_valid) begin
                m2_dv++;
                if (exp_q2.size() == 0) chk("m2_unexpected_data", {24'h0, m2_data_in}, 32'hFFFF_FFFF);
                else chk("m2_read_data", {24'h0, m2_data_in}, {24'h0, exp_q2.pop_front()});
            end
            if (m1_split_ack) m1_sa++;
            if (m2_split_ack) m2_sa++;
        end
    end

    task automatic drive(input int m, input logic req, input logic [15:0] a, input logic av,
                         input logic [7:0] d, input logic dv, input logic rw);
        if (m == 1) begin
            m1_req = req; m1_address_out = a; m1_address_out_valid = av;
            m1_data_out = d; m1_data_out_valid = dv; m1_rw = rw;
        end else begin
            m2_req = req; m2_address_out = a; m2_address_out_valid = av;
            m2_data_out = d; m2_data_out_valid = dv; m2_rw = rw;
        end
    endtask

    // One master transaction: request, wait grant, present, wait ack/split, release.
    task automatic txn(input int m, input logic [15:0] a, input logic [7:0] d,
                       input logic rw, output int lat);
        int  n;
        logic hit;
        lat = 0;
        rcyc[m] = cyc;
        drive(m, 1'b1, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        n = 0; hit = 1'b0;
        while (!hit && n < 100) begin
            @(posedge clk); #1; n++;
            hit = (m == 1) ? m1_grant : m2_grant;
        end
        chk($sformatf("m%0d_grant_wait", m), {31'h0, hit}, 32'h1);
        gcyc[m] = cyc;
        if (hit) begin
            if (!rw) begin
                if (m == 1) exp_q1.push_back(d);
                else        exp_q2.push_back(d);
            end
            drive(m, 1'b1, a, 1'b1, rw ? d : 8'h00, rw, rw);
            n = 0; hit = 1'b0;
            while (!hit && n < 100) begin
                @(posedge clk); #1; n++;
                hit = (m == 1) ? (m1_ack || m1_split_ack) : (m2_ack || m2_split_ack);
            end
            lat = n;
            chk($sformatf("m%0d_ack_wait_%0h", m, a), {31'h0, hit}, 32'h1);
        end
        drive(m, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        relcyc[m] = cyc;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q1.size() != 0 || exp_q2.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("scoreboard_drained", exp_q1.size() + exp_q2.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, dv0, n;
        logic hit;
        rst_n = 1'b0;
        m1_ready = 1'b1; m2_ready = 1'b1;
        s1_ready = 1'b1; s2_ready = 1'b1; split_s_ready = 1'b1;
        drive(1, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(2, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", {31'h0, |all_out}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // m1 write/read s2
        txn(1, 16'h4004, 8'hA7, 1'b1, lat);
        txn(1, 16'h4004, 8'hA7, 1'b0, lat);
        wait_drain();
        chk("s2_writes", s2_wr, 1);
        chk("s2_reads", s2_rd, 1);
        chk("m1_dv_count_a", m1_dv, 1);
        chk("s1_idle_a", s1_av, 0);
        chk("split_idle_a", sp_wr + sp_rd, 0);

        // m2 write/read split slave with deferred read
        txn(2, 16'h8004, 8'h5E, 1'b1, lat);
        txn(2, 16'h8004, 8'h5E, 1'b0, lat);
        wait_drain();
        chk("sp_writes", sp_wr, 1);
        chk("sp_reads", sp_rd, 1);
        chk("sp_split_acks", sp_sa, 1);
        chk("sp_data_out_valids", sp_dov, 1);
        chk("m2_split_ack_count", m2_sa, 1);
        chk("m2_dv_count_b", m2_dv, 1);
        chk("s1_idle_b", s1_av, 0);

        // split pending on m2 while m1 uses s1; resume must go to m2
        txn(2, 16'h8004, 8'h5E, 1'b0, lat);
        txn(1, 16'h0010, 8'h3C, 1'b1, lat);
        txn(1, 16'h0010, 8'h3C, 1'b0, lat);
        wait_drain();
        chk("m2_dv_count_c", m2_dv, 2);
        chk("m1_dv_count_c", m1_dv, 2);
        chk("m2_split_ack_count_c", m2_sa, 2);
        chk("s1_accesses_c", s1_wr + s1_rd, 2);

        // simultaneous requests
        fork
            begin int l1; txn(1, 16'h0050, 8'h11, 1'b1, l1); end
            begin int l2; txn(2, 16'h4010, 8'h22, 1'b1, l2); end
        join
        chk("m1_granted_first", {31'h0, gcyc[1] < gcyc[2]}, 32'h1);
        chk("m2_after_m1_release", {31'h0, gcyc[2] > relcyc[1]}, 32'h1);
        fork
            begin int l3; txn(1, 16'h0050, 8'h11, 1'b0, l3); end
            begin int l4; txn(2, 16'h4010, 8'h22, 1'b0, l4); end
        join
        wait_drain();

        // unmapped region
        dv0 = m1_dv;
        txn(1, 16'hC000, 8'h99, 1'b1, lat);
        chk("unmapped_write_ack_latency", lat, 1);
        txn(1, 16'hC000, 8'h00, 1'b0, lat);
        chk("unmapped_read_ack_latency", lat, 1);
        wait_drain();
        chk("unmapped_read_one_valid", m1_dv - dv0, 1);
        chk("m1_never_split", m1_sa, 0);

        // stall while target not ready
        s1_ready = 1'b0;
        fork
            txn(1, 16'h0060, 8'h77, 1'b1, lat);
            begin
                repeat (4) @(posedge clk);
                #2;
                chk("stall_valid_held_low", {31'h0, s1_address_in_valid}, 32'h0);
                chk("stall_no_ack", {31'h0, m1_ack}, 32'h0);
                s1_ready = 1'b1;
            end
        join
        chk("stall_extends_latency", {31'h0, lat > 1}, 32'h1);
        txn(1, 16'h0060, 8'h77, 1'b0, lat);
        wait_drain();

        // reset during a granted write
        m1_req = 1'b1;
        #1;
        chk("grant_is_registered", {31'h0, m1_grant}, 32'h0);
        n = 0; hit = 1'b0;
        while (!hit && n < 100) begin
            @(posedge clk); #1; n++;
            hit = m1_grant;
        end
        chk("reset_test_grant", {31'h0, hit}, 32'h1);
        drive(1, 1'b1, 16'h4020, 1'b1, 8'hEE, 1'b1, 1'b1);
        #1;
        chk("s2_fwd_valid", {31'h0, s2_address_in_valid}, 32'h1);
        chk("s2_fwd_addr", {16'h0, s2_address_in}, 32'h4020);
        chk("s1_not_selected", {31'h0, s1_address_in_valid}, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("outputs_zero_in_reset", {31'h0, |all_out}, 32'h0);
        drive(1, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        txn(2, 16'h4020, 8'h5A, 1'b1, lat);
        txn(2, 16'h4020, 8'h5A, 1'b0, lat);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
